// File: rtl/fixed_predictor_decoder.sv
// Fixed-order linear predictor decoder: rebuilds signed samples from warmup
// samples and residuals using a 4-deep sample history, one sample per cycle.
module fixed_predictor_decoder #(
    parameter int SAMPLE_W = 16,
    parameter int RESID_W  = 24,
    parameter int BLOCK_W  = 16
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iStart,
    input  logic [2:0]                 iOrder,
    input  logic [BLOCK_W-1:0]         iBlockSize,
    input  logic signed [RESID_W-1:0]  iResidual,
    input  logic                       iResidualValid,
    output logic                       oResidualReady,
    output logic signed [SAMPLE_W-1:0] oSample,
    output logic                       oSampleValid,
    input  logic                       iSampleReady,
    output logic                       oFrameDone,
    output logic                       oBusy,
    output logic                       oError
);
    localparam int PW = SAMPLE_W + RESID_W + 4;

    typedef enum logic [1:0] {IDLE, WARMUP, RESIDUAL, DONE} state_t;

    state_t                      state_q;
    logic [2:0]                  order_q;
    logic [BLOCK_W-1:0]          size_q, cnt_q, cnt_inc;
    logic signed [SAMPLE_W-1:0]  s1_q, s2_q, s3_q, s4_q;
    logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                        valid_q, fdone_q, err_q;
    logic                        xfer, last;
    logic signed [PW-1:0]        e1, e2, e3, e4, e_res, pred;

    assign oResidualReady = ((state_q == WARMUP) || (state_q == RESIDUAL)) &&
                            (!valid_q || iSampleReady);
    assign xfer    = iResidualValid && oResidualReady;
    assign cnt_inc = cnt_q + BLOCK_W'(1);
    assign last    = (cnt_inc == size_q);

    assign oSample      = sample_q;
    assign oSampleValid = valid_q;
    assign oFrameDone   = fdone_q;
    assign oBusy        = (state_q != IDLE);
    assign oError       = err_q;

    assign e1    = PW'(s1_q);
    assign e2    = PW'(s2_q);
    assign e3    = PW'(s3_q);
    assign e4    = PW'(s4_q);
    assign e_res = PW'(iResidual);

    // Shift-and-add forms of the binomial predictor coefficients
    always_comb begin
        pred = '0;
        case (order_q)
            3'd1:    pred = e1;
            3'd2:    pred = (e1 <<< 1) - e2;
            3'd3:    pred = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
            3'd4:    pred = (e1 <<< 2) - (e2 <<< 2) - (e2 <<< 1) + (e3 <<< 2) - e4;
            default: pred = '0;
        endcase
        sample_d = (state_q == RESIDUAL) ? SAMPLE_W'(e_res + pred) : SAMPLE_W'(iResidual);
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q  <= IDLE;
            order_q  <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            s4_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            fdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        if (iOrder > 3'd4) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            order_q <= iOrder;
                            size_q  <= iBlockSize;
                            cnt_q   <= '0;
                            s1_q    <= '0;
                            s2_q    <= '0;
                            s3_q    <= '0;
                            s4_q    <= '0;
                            if (iBlockSize == '0) begin
                                state_q <= DONE;
                                fdone_q <= 1'b1;
                            end else if (iOrder == 3'd0) begin
                                state_q <= RESIDUAL;
                            end else begin
                                state_q <= WARMUP;
                            end
                        end
                    end
                end
                WARMUP, RESIDUAL: begin
                    if (xfer) begin
                        sample_q <= sample_d;
                        valid_q  <= 1'b1;
                        fdone_q  <= last;
                        s1_q     <= sample_d;
                        s2_q     <= s1_q;
                        s3_q     <= s2_q;
                        s4_q     <= s3_q;
                        cnt_q    <= cnt_inc;
                        // Block end wins over the warmup->residual switch
                        if (last)
                            state_q <= DONE;
                        else if (state_q == WARMUP && cnt_inc == BLOCK_W'(order_q))
                            state_q <= RESIDUAL;
                    end else if (iSampleReady) begin
                        valid_q <= 1'b0;
                        fdone_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (!valid_q || iSampleReady) begin
                        valid_q <= 1'b0;
                        fdone_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Bench for fixed_predictor_decoder: vector table driven through a scoreboard
// queue, plus hand sequences for illegal order, empty block and reset.
module tb_fixed_predictor_decoder;
    localparam int SW = 16;
    localparam int RW = 24;
    localparam int BW = 16;

    logic                 iClock = 1'b0;
    logic                 iReset, iStart, iResidualValid, iSampleReady;
    logic [2:0]           iOrder;
    logic [BW-1:0]        iBlockSize;
    logic signed [RW-1:0] iResidual;
    logic                 oResidualReady, oSampleValid, oFrameDone, oBusy, oError;
    logic signed [SW-1:0] oSample;

    always #5 iClock = ~iClock;

    fixed_predictor_decoder #(.SAMPLE_W(SW), .RESID_W(RW), .BLOCK_W(BW)) dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iOrder(iOrder),
        .iBlockSize(iBlockSize), .iResidual(iResidual), .iResidualValid(iResidualValid),
        .oResidualReady(oResidualReady), .oSample(oSample), .oSampleValid(oSampleValid),
        .iSampleReady(iSampleReady), .oFrameDone(oFrameDone), .oBusy(oBusy), .oError(oError)
    );

    typedef struct {
        int order; int size; int stall; int abort;
        int res[8]; int exp[8];
    } vec_t;
    typedef struct { int s; bit last; } exp_t;

    vec_t vt[13];
    exp_t sbq[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic chk(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   idx, pops, cyc, stall, hval, w;
        bit   held;
        exp_t e;
        iStart = 1'b1; iOrder = 3'(v.order); iBlockSize = BW'(v.size);
        @(posedge iClock); #1;
        iStart = 1'b0;
        idx = 0; pops = 0; cyc = 0; stall = v.stall; held = 1'b0; hval = 0;
        iResidualValid = (v.size > 0);
        iResidual = RW'(v.res[0]);
        iSampleReady = (stall == 0);
        while ((idx < v.size || sbq.size() != 0) && cyc < 100 &&
               !(v.abort > 0 && pops == v.abort)) begin
            @(negedge iClock);
            cyc++;
            if (held) begin
                chk("hold_valid", int'(oSampleValid), 1);
                chk("hold_sample", hval, int'(oSample));
            end
            if (oSampleValid && !iSampleReady) begin
                chk("stall_ready", int'(oResidualReady), 0);
                if (stall > 0) stall--;
            end
            if (oSampleValid && iSampleReady) begin
                if (sbq.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("sample", int'(oSample), e.s);
                    chk("frame_done", int'(oFrameDone), int'(e.last));
                    pops++;
                end
            end
            held = oSampleValid && !iSampleReady;
            hval = int'(oSample);
            if (iResidualValid && oResidualReady) begin
                sbq.push_back('{v.exp[idx], (idx == v.size - 1)});
                idx++;
            end
            @(posedge iClock); #1;
            iResidualValid = (idx < v.size);
            if (idx < v.size) iResidual = RW'(v.res[idx]);
            iSampleReady = (stall == 0);
        end
        if (cyc >= 100) chk("timeout", cyc, 0);
        iResidualValid = 1'b0;
        iSampleReady = 1'b1;
        if (v.abort > 0) begin
            iReset = 1'b0;
            @(posedge iClock);
            @(negedge iClock);
            chk("rst_sample", int'(oSample), 0);
            chk("rst_valid", int'(oSampleValid), 0);
            chk("rst_ready", int'(oResidualReady), 0);
            chk("rst_fdone", int'(oFrameDone), 0);
            chk("rst_busy", int'(oBusy), 0);
            chk("rst_error", int'(oError), 0);
            @(posedge iClock); #1;
            iReset = 1'b1;
            sbq.delete();
        end else begin
            if (v.stall == 0) chk("throughput_cycles", cyc, v.size + 1);
            w = 0;
            @(negedge iClock);
            while (oBusy && w < 5) begin
                @(negedge iClock);
                w++;
            end
            chk("back_idle", int'(oBusy), 0);
            chk("no_error", int'(oError), 0);
            @(posedge iClock); #1;
        end
    endtask

    initial begin
        //          order size stall abort residuals                      expected samples
        vt[0]  = '{1, 4, 0, 0, '{100, 2, -3, 5, 0, 0, 0, 0},         '{100, 102, 99, 104, 0, 0, 0, 0}};
        vt[1]  = '{4, 5, 0, 0, '{1, 2, 3, 4, 0, 0, 0, 0},            '{1, 2, 3, 4, 5, 0, 0, 0}};
        vt[2]  = '{2, 4, 0, 0, '{10, 20, 0, 1, 0, 0, 0, 0},          '{10, 20, 30, 41, 0, 0, 0, 0}};
        vt[3]  = '{1, 2, 0, 0, '{32767, 1, 0, 0, 0, 0, 0, 0},        '{32767, -32768, 0, 0, 0, 0, 0, 0}};
        vt[4]  = '{0, 2, 3, 0, '{-5, 7, 0, 0, 0, 0, 0, 0},           '{-5, 7, 0, 0, 0, 0, 0, 0}};
        vt[5]  = '{3, 5, 0, 0, '{1, 4, 9, 0, 0, 0, 0, 0},            '{1, 4, 9, 16, 25, 0, 0, 0}};
        vt[6]  = '{4, 2, 0, 0, '{7, -8, 0, 0, 0, 0, 0, 0},           '{7, -8, 0, 0, 0, 0, 0, 0}};
        vt[7]  = '{1, 2, 0, 0, '{74565, 1, 0, 0, 0, 0, 0, 0},        '{9029, 9030, 0, 0, 0, 0, 0, 0}};
        vt[8]  = '{2, 6, 2, 0, '{3, 5, 0, 0, 0, 0, 0, 0},            '{3, 5, 7, 9, 11, 13, 0, 0}};
        vt[9]  = '{2, 3, 0, 0, '{30000, 32000, 0, 0, 0, 0, 0, 0},    '{30000, 32000, -31536, 0, 0, 0, 0, 0}};
        vt[10] = '{4, 8, 0, 0, '{0, 0, 0, 1, 0, 0, 0, 0},            '{0, 0, 0, 1, 4, 10, 20, 35}};
        vt[11] = '{2, 8, 0, 3, '{10, 20, 0, 0, 0, 0, 0, 0},          '{10, 20, 30, 40, 50, 60, 70, 80}};
        vt[12] = '{2, 3, 0, 0, '{5, 5, 1, 0, 0, 0, 0, 0},            '{5, 5, 6, 0, 0, 0, 0, 0}};

        iReset = 1'b0; iStart = 1'b0; iOrder = '0; iBlockSize = '0;
        iResidual = '0; iResidualValid = 1'b0; iSampleReady = 1'b1;
        repeat (2) @(posedge iClock);
        @(negedge iClock);
        chk("reset_sample", int'(oSample), 0);
        chk("reset_valid", int'(oSampleValid), 0);
        chk("reset_ready", int'(oResidualReady), 0);
        chk("reset_fdone", int'(oFrameDone), 0);
        chk("reset_busy", int'(oBusy), 0);
        chk("reset_error", int'(oError), 0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // Illegal order: flag set, nothing accepted or emitted
        iStart = 1'b1; iOrder = 3'd5; iBlockSize = BW'(3);
        @(posedge iClock); #1;
        iStart = 1'b0; iResidualValid = 1'b1; iResidual = RW'(9);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClock);
            chk("err_flag", int'(oError), 1);
            chk("err_no_valid", int'(oSampleValid), 0);
            chk("err_not_busy", int'(oBusy), 0);
            chk("err_no_ready", int'(oResidualReady), 0);
            @(posedge iClock); #1;
        end
        // Empty block clears the flag and pulses frame-done alone
        iResidualValid = 1'b0;
        iStart = 1'b1; iOrder = 3'd1; iBlockSize = '0;
        @(posedge iClock); #1;
        iStart = 1'b0;
        @(negedge iClock);
        chk("empty_err_clr", int'(oError), 0);
        chk("empty_fdone", int'(oFrameDone), 1);
        chk("empty_valid", int'(oSampleValid), 0);
        chk("empty_busy", int'(oBusy), 1);
        @(negedge iClock);
        chk("empty_fdone_end", int'(oFrameDone), 0);
        chk("empty_idle", int'(oBusy), 0);
        chk("empty_valid_end", int'(oSampleValid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/fixed_predictor_decoder.md
FIXED_PREDICTOR_DECODER -- requirements
Module: fixed_predictor_decoder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning output sample width in bits (signed).
REQ-002 SHALL have parameter RESID_W, default 24, meaning input residual/warmup width in bits (signed).
REQ-003 SHALL have parameter BLOCK_W, default 16, meaning block-size counter width.
REQ-004 SHALL have port iClock  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port iReset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port iStart  input  1  one-cycle pulse; begins a block.
REQ-007 SHALL have port iOrder  input  3  fixed predictor order 0..4, sampled on iStart.
REQ-008 SHALL have port iBlockSize  input  BLOCK_W  samples in block, sampled on iStart.
REQ-009 SHALL have port iResidual  input  RESID_W  signed warmup sample or residual.
REQ-010 SHALL have port iResidualValid  input  1  iResidual is valid.
REQ-011 SHALL have port oResidualReady  output  1  block accepts iResidual this cycle.
REQ-012 SHALL have port oSample  output  SAMPLE_W  signed reconstructed sample.
REQ-013 SHALL have port oSampleValid  output  1  oSample is valid.
REQ-014 SHALL have port iSampleReady  input  1  consumer accepts oSample.
REQ-015 SHALL have port oFrameDone  output  1  marks the final sample of the block.
REQ-016 SHALL have port oBusy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port oError  output  1  sticky illegal-order flag.

Function
REQ-018 SHALL implement states IDLE, WARMUP, RESIDUAL, DONE.
REQ-019 IDLE: on iStart with iOrder<=4, SHALL latch order and block size, clear the sample counter, and go to WARMUP (order>0, size>0), RESIDUAL (order=0, size>0), or DONE (size=0).
REQ-020 IDLE: on iStart with iOrder>4, SHALL set oError, remain in IDLE, and emit no samples; oError clears only on the next legal iStart or reset.
REQ-021 iStart outside IDLE SHALL be ignored.
REQ-022 Input handshake: a transfer occurs when iResidualValid && oResidualReady.
REQ-023 oResidualReady SHALL be high only in WARMUP/RESIDUAL while (!oSampleValid || iSampleReady).
REQ-024 WARMUP: each transfer SHALL be emitted verbatim as a sample, truncated to SAMPLE_W; the state advances to RESIDUAL after `order` transfers.
REQ-025 RESIDUAL: sample = residual + prediction, using history s1 (newest) .. s4 (oldest):
  o0: 0; o1: s1; o2: 2s1-s2; o3: 3s1-3s2+s3; o4: 4s1-6s2+4s3-s4.
REQ-026 Prediction SHALL use SAMPLE_W+RESID_W+4-bit signed arithmetic; the result SHALL wrap (two's complement truncation) to SAMPLE_W with no saturation.
REQ-027 Each emitted sample SHALL shift the 4-entry history (s1<=sample).
REQ-028 Latency: a transfer in cycle N SHALL present the sample on oSample with oSampleValid=1 in cycle N+1.
REQ-029 Output handshake: oSample and oSampleValid SHALL hold stable until iSampleReady=1; oSampleValid SHALL drop in the following cycle unless a new transfer occurs in the same cycle.
REQ-030 Back-to-back: with iSampleReady and iResidualValid both held high, SHALL sustain one sample per cycle.
REQ-031 When the transfer count reaches the block size, the state SHALL go to DONE; oFrameDone SHALL be high exactly while the final sample is valid.
REQ-032 If block size < order, only block-size warmup samples SHALL be emitted, and the final one SHALL carry oFrameDone.
REQ-033 DONE: after the final sample handshakes, the state SHALL return to IDLE; for block size 0, oFrameDone SHALL pulse for one cycle with oSampleValid=0, then the state returns to IDLE.
REQ-034 History registers SHALL be cleared on every legal iStart.

Reset
REQ-035 On iReset=0 at a clock edge: state IDLE; oSample=0; oSampleValid=0; oResidualReady=0; oFrameDone=0; oBusy=0; oError=0; history and counter cleared.
REQ-036 Reset mid-block SHALL abort the block immediately and discard the pending output sample.

Verification
REQ-037 Order 1, size 4, inputs 100,2,-3,5, iSampleReady=1 -> samples 100,102,99,104 on consecutive cycles, oFrameDone with 104.
REQ-038 Order 4, size 5, inputs 1,2,3,4,0 -> 1,2,3,4,5; order 2, size 4, inputs 10,20,0,1 -> 10,20,30,41.
REQ-039 SAMPLE_W=16, order 1, inputs 32767,1 -> 32767, then -32768 (wrap).
REQ-040 Order 0, size 2, inputs -5,7, with iSampleReady low for 3 cycles on the first sample -> -5 held stable, oResidualReady=0 throughout, then 7; no loss or duplication.
REQ-041 iOrder=5 -> oError=1, no oSampleValid; then order 1, size 0 -> oError=0, single oFrameDone pulse, back in IDLE.
REQ-042 Order 2, size 8, iReset=0 after 3 samples -> all outputs at reset values next cycle; a new block then decodes from clean history.
